// File: rtl/decode_stage_p_if.sv
// Fetch/execute/write-back bundle for decode_stage_p.
// The slave modport is the decode side; the master modport is its environment.
interface decode_stage_p_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc_i;
  logic            flush;
  logic            ex_ready;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_value;
  logic            out_valid;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] pc_o;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            write_back;
  logic            imm_flag;
  logic            mem_acc;
  logic            load_flag;
  logic            store_flag;
  logic            branch_flag;
  logic            jump_flag;
  logic            word_inst;
  logic            illegal;
  logic            stall_raise;

  modport slave (
    input  in_valid, inst, pc_i, flush, ex_ready, wb_en, wb_rd, wb_value,
    output in_ready, out_valid, out_inst, pc_o, rd, rs1, rs2, funct3, funct7,
           imm, op1, op2, rs1_val, rs2_val, write_back, imm_flag, mem_acc,
           load_flag, store_flag, branch_flag, jump_flag, word_inst, illegal,
           stall_raise
  );

  modport master (
    output in_valid, inst, pc_i, flush, ex_ready, wb_en, wb_rd, wb_value,
    input  in_ready, out_valid, out_inst, pc_o, rd, rs1, rs2, funct3, funct7,
           imm, op1, op2, rs1_val, rs2_val, write_back, imm_flag, mem_acc,
           load_flag, store_flag, branch_flag, jump_flag, word_inst, illegal,
           stall_raise
  );
endinterface

// File: rtl/decode_stage_p.sv
// RV32I/RV64I decode stage: register file with write-back bypass, load-use
// hazard detection and a single registered ID/EX slot behind valid/ready.
module decode_stage_p #(
  parameter int          XLEN = 64,
  parameter int          NREG = 32,
  parameter logic [31:0] NOP  = 32'h00000013
) (
  input logic             CLK,
  input logic             reset,
  decode_stage_p_if.slave bus
);
  localparam int         IDXW   = $clog2(NREG);
  localparam logic [5:0] NREG_W = 6'(NREG);
  localparam bit         IS64   = (XLEN == 64);

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            write_back;
    logic            imm_flag;
    logic            mem_acc;
    logic            load_flag;
    logic            store_flag;
    logic            branch_flag;
    logic            jump_flag;
    logic            word_inst;
    logic            illegal;
  } slot_t;

  function automatic logic idx_bad(input logic [4:0] idx);
    return ({1'b0, idx} >= NREG_W);
  endfunction

  function automatic slot_t bubble_slot();
    slot_t s;
    s      = '0;
    s.inst = NOP;
    return s;
  endfunction

  logic [XLEN-1:0] rf_r [NREG];
  slot_t           slot_r;
  slot_t           dec_s;
  logic [XLEN-1:0] v1_s, v2_s;
  logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic            uses_rs1_s, uses_rs2_s, has_rd_s, known_s;
  logic            hazard_s, advance_s;

  wire [6:0] opcode_s  = bus.inst[6:0];
  wire [4:0] rd_idx_s  = bus.inst[11:7];
  wire [4:0] rs1_idx_s = bus.inst[19:15];
  wire [4:0] rs2_idx_s = bus.inst[24:20];

  assign imm_i_s = XLEN'($signed(bus.inst[31:20]));
  assign imm_s_s = XLEN'($signed({bus.inst[31:25], bus.inst[11:7]}));
  assign imm_b_s = XLEN'($signed({bus.inst[31], bus.inst[7], bus.inst[30:25],
                                  bus.inst[11:8], 1'b0}));
  assign imm_u_s = XLEN'($signed({bus.inst[31:12], 12'h000}));
  assign imm_j_s = XLEN'($signed({bus.inst[31], bus.inst[19:12], bus.inst[20],
                                  bus.inst[30:21], 1'b0}));

  // Bypassed register reads: x0 and out-of-range indices read as zero.
  always_comb begin
    v1_s = '0;
    v2_s = '0;
    if (rs1_idx_s == 5'd0 || idx_bad(rs1_idx_s)) v1_s = '0;
    else if (bus.wb_en && bus.wb_rd == rs1_idx_s) v1_s = bus.wb_value;
    else v1_s = rf_r[rs1_idx_s[IDXW-1:0]];
    if (rs2_idx_s == 5'd0 || idx_bad(rs2_idx_s)) v2_s = '0;
    else if (bus.wb_en && bus.wb_rd == rs2_idx_s) v2_s = bus.wb_value;
    else v2_s = rf_r[rs2_idx_s[IDXW-1:0]];
  end

  // Instruction decode into a candidate slot.
  always_comb begin
    dec_s       = '0;
    dec_s.valid = 1'b1;
    dec_s.inst  = bus.inst;
    dec_s.pc    = bus.pc_i;
    uses_rs1_s  = 1'b0;
    uses_rs2_s  = 1'b0;
    has_rd_s    = 1'b0;
    known_s     = 1'b1;
    case (opcode_s)
      OPC_OP, OPC_OP32: begin
        uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; has_rd_s = 1'b1;
        dec_s.funct7 = bus.inst[31:25];
        dec_s.op1 = v1_s; dec_s.op2 = v2_s;
        dec_s.rs1_val = v1_s; dec_s.rs2_val = v2_s;
        dec_s.write_back = 1'b1;
        dec_s.word_inst  = (opcode_s == OPC_OP32);
        known_s = (opcode_s == OPC_OP) || IS64;
      end
      OPC_OPIMM, OPC_OPIMM32, OPC_LOAD: begin
        uses_rs1_s = 1'b1; has_rd_s = 1'b1;
        dec_s.imm = imm_i_s; dec_s.op1 = v1_s; dec_s.op2 = imm_i_s;
        dec_s.rs1_val = v1_s;
        dec_s.imm_flag = 1'b1; dec_s.write_back = 1'b1;
        dec_s.mem_acc   = (opcode_s == OPC_LOAD);
        dec_s.load_flag = (opcode_s == OPC_LOAD);
        dec_s.word_inst = (opcode_s == OPC_OPIMM32);
        known_s = (opcode_s != OPC_OPIMM32) || IS64;
      end
      OPC_STORE: begin
        uses_rs1_s = 1'b1; uses_rs2_s = 1'b1;
        dec_s.imm = imm_s_s; dec_s.op1 = v1_s; dec_s.op2 = imm_s_s;
        dec_s.rs1_val = v1_s; dec_s.rs2_val = v2_s;
        dec_s.mem_acc = 1'b1; dec_s.store_flag = 1'b1;
      end
      OPC_BRANCH: begin
        uses_rs1_s = 1'b1; uses_rs2_s = 1'b1;
        dec_s.imm = imm_b_s; dec_s.op1 = v1_s; dec_s.op2 = v2_s;
        dec_s.rs1_val = v1_s; dec_s.rs2_val = v2_s;
        dec_s.branch_flag = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        has_rd_s = 1'b1;
        dec_s.imm = imm_u_s; dec_s.op2 = imm_u_s;
        dec_s.op1 = (opcode_s == OPC_AUIPC) ? bus.pc_i : '0;
        dec_s.write_back = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        has_rd_s   = 1'b1;
        uses_rs1_s = (opcode_s == OPC_JALR);
        dec_s.imm  = (opcode_s == OPC_JALR) ? imm_i_s : imm_j_s;
        dec_s.rs1_val = (opcode_s == OPC_JALR) ? v1_s : '0;
        dec_s.op1 = bus.pc_i; dec_s.op2 = XLEN'(3'd4);
        dec_s.jump_flag = 1'b1; dec_s.write_back = 1'b1;
      end
      default: known_s = 1'b0;
    endcase
    if (has_rd_s) dec_s.rd = rd_idx_s;
    else dec_s.rd = 5'd0;
    if (uses_rs1_s) dec_s.rs1 = rs1_idx_s;
    else dec_s.rs1 = 5'd0;
    if (uses_rs2_s) dec_s.rs2 = rs2_idx_s;
    else dec_s.rs2 = 5'd0;
    if (uses_rs1_s || uses_rs2_s || opcode_s == OPC_JALR) dec_s.funct3 = bus.inst[14:12];
    else dec_s.funct3 = 3'd0;
    // Illegal words still occupy a valid slot, but carry nothing else.
    if (!known_s || (has_rd_s && idx_bad(rd_idx_s)) || (uses_rs1_s && idx_bad(rs1_idx_s))
        || (uses_rs2_s && idx_bad(rs2_idx_s))) begin
      dec_s         = '0;
      dec_s.valid   = 1'b1;
      dec_s.inst    = bus.inst;
      dec_s.pc      = bus.pc_i;
      dec_s.illegal = 1'b1;
    end else begin
      dec_s.illegal = 1'b0;
    end
  end

  assign hazard_s = slot_r.valid & slot_r.load_flag & (slot_r.rd != 5'd0) &
                    ((uses_rs1_s & (rs1_idx_s == slot_r.rd)) |
                     (uses_rs2_s & (rs2_idx_s == slot_r.rd)));
  assign advance_s       = !slot_r.valid | bus.ex_ready;
  assign bus.stall_raise = bus.in_valid & hazard_s;
  assign bus.in_ready    = advance_s & !hazard_s & !bus.flush;

  // Register file write port.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_r[i] <= '0;
    end else if (bus.wb_en && bus.wb_rd != 5'd0 && !idx_bad(bus.wb_rd)) begin
      rf_r[bus.wb_rd[IDXW-1:0]] <= bus.wb_value;
    end
  end

  // ID/EX slot: flush and load-use both insert a bubble; stalled EX holds.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) slot_r <= bubble_slot();
    else if (bus.flush) slot_r <= bubble_slot();
    else if (advance_s && hazard_s) slot_r <= bubble_slot();
    else if (advance_s && bus.in_valid) slot_r <= dec_s;
    else if (advance_s) slot_r <= bubble_slot();
  end

  assign bus.out_valid   = slot_r.valid;
  assign bus.out_inst    = slot_r.inst;
  assign bus.pc_o        = slot_r.pc;
  assign bus.rd          = slot_r.rd;
  assign bus.rs1         = slot_r.rs1;
  assign bus.rs2         = slot_r.rs2;
  assign bus.funct3      = slot_r.funct3;
  assign bus.funct7      = slot_r.funct7;
  assign bus.imm         = slot_r.imm;
  assign bus.op1         = slot_r.op1;
  assign bus.op2         = slot_r.op2;
  assign bus.rs1_val     = slot_r.rs1_val;
  assign bus.rs2_val     = slot_r.rs2_val;
  assign bus.write_back  = slot_r.write_back;
  assign bus.imm_flag    = slot_r.imm_flag;
  assign bus.mem_acc     = slot_r.mem_acc;
  assign bus.load_flag   = slot_r.load_flag;
  assign bus.store_flag  = slot_r.store_flag;
  assign bus.branch_flag = slot_r.branch_flag;
  assign bus.jump_flag   = slot_r.jump_flag;
  assign bus.word_inst   = slot_r.word_inst;
  assign bus.illegal     = slot_r.illegal;
endmodule
